// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   localparam int unsigned FETCH_XLEN = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [FETCH_XLEN-1:0] PC_STEP = FETCH_XLEN'(3'd4);

   typedef struct packed {
      logic [FETCH_XLEN-1:0] pc;
      logic [31:0]           instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries with clear; push and pop may
// happen in the same cycle while not full.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output fetch_entry_t head,
   output logic [AW:0]  count,
   output logic         full,
   output logic         empty
);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == (AW+1)'(0));
   assign do_pop  = pop & ~empty;
   assign do_push = push & ~full;
   assign head    = mem[rd_ptr];

   // Storage is data only; validity comes from the pointers and count.
   always_ff @(posedge clk) begin
      if (do_push && !clear) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr <= AW'(0);
         rd_ptr <= AW'(0);
         count  <= (AW+1)'(0);
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with F/D pipeline register.
// Optional feature macro: FETCH_BUBBLE_CNT_EN adds the perf_bubbles counter port.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned     XLEN       = FETCH_XLEN,
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned     FIFO_DEPTH = 2,
   parameter int unsigned     MAX_OUTST  = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            f_stall,
   input  logic            d_stall,
   input  logic            d_flush,
   input  logic            e_pc_src,
   input  logic [XLEN-1:0] e_pc_target,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
`ifdef FETCH_BUBBLE_CNT_EN
   output logic [31:0]     perf_bubbles,
`endif
   output logic [31:0]     d_instr,
   output logic [XLEN-1:0] d_pc,
   output logic [XLEN-1:0] d_pc_plus4,
   output logic            d_valid
);

   localparam int unsigned CW = $clog2(MAX_OUTST + 1);
   localparam int unsigned TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int unsigned FW = $clog2(FIFO_DEPTH);

   logic [XLEN-1:0] f_pc, hold_addr, redirect_pc;
   logic            req_hold, hold_stale;
   logic [CW-1:0]   outst, drop;
   logic [XLEN-1:0] tag_q [MAX_OUTST];
   logic [TW-1:0]   tag_wr, tag_rd;
   fetch_entry_t    fifo_head, rsp_entry;
   logic [FW:0]     fifo_count;
   logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic            issue_ok, accept, stale_accept, rsp, rsp_keep, advance, bypass;

   function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
      if (p == TW'(MAX_OUTST - 1)) return TW'(0);
      else return p + TW'(1);
   endfunction

   assign redirect_pc  = e_pc_target & ~XLEN'(3);
   assign issue_ok     = ~f_stall & ~e_pc_src & (outst < CW'(MAX_OUTST)) &
                         ((32'(fifo_count) + 32'(outst)) < FIFO_DEPTH);
   assign imem_req_valid = ~rst & (req_hold | issue_ok);
   assign imem_req_addr  = req_hold ? hold_addr : f_pc;
   assign accept       = imem_req_valid & imem_req_ready;
   assign stale_accept = accept & req_hold & hold_stale;
   // A response with nothing in flight is spurious and ignored.
   assign rsp          = imem_rsp_valid & (outst != CW'(0));
   assign rsp_keep     = rsp & (drop == CW'(0)) & ~e_pc_src;
   assign advance      = ~d_flush & ~d_stall;
   assign bypass       = rsp_keep & fifo_empty & advance;
   assign fifo_push    = rsp_keep & ~bypass & ~fifo_full;
   assign fifo_pop     = advance & ~fifo_empty & ~e_pc_src;
   assign rsp_entry    = '{pc: tag_q[tag_rd], instr: imem_rsp_data};

   // Fetch PC, held request and in-flight/drop counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         f_pc       <= RESET_PC;
         hold_addr  <= RESET_PC;
         req_hold   <= 1'b0;
         hold_stale <= 1'b0;
         outst      <= CW'(0);
         drop       <= CW'(0);
      end else begin
         req_hold   <= imem_req_valid & ~imem_req_ready;
         hold_stale <= imem_req_valid & ~imem_req_ready & (hold_stale | e_pc_src);
         if (imem_req_valid && !imem_req_ready && !req_hold) hold_addr <= f_pc;
         outst <= outst + CW'(accept) - CW'(rsp);
         if (e_pc_src) begin
            f_pc <= redirect_pc;
            drop <= outst + CW'(accept) - CW'(rsp);
         end else begin
            // A request issued before a redirect belongs to the old path.
            if (accept && !stale_accept) f_pc <= f_pc + PC_STEP;
            drop <= drop + CW'(stale_accept) - CW'(rsp & (drop != CW'(0)));
         end
      end
   end

   // In-order PC tags of accepted requests, consumed by responses.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_wr <= TW'(0);
         tag_rd <= TW'(0);
      end else begin
         if (accept) tag_wr <= tag_next(tag_wr);
         if (rsp)    tag_rd <= tag_next(tag_rd);
      end
   end

   always_ff @(posedge clk) begin
      if (accept && !rst) tag_q[tag_wr] <= imem_req_addr;
   end

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (e_pc_src),
      .push      (fifo_push),
      .push_data (rsp_entry),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // F/D register: flush beats stall beats advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         d_valid    <= 1'b0;
         d_instr    <= NOP_INSTR;
         d_pc       <= XLEN'(0);
         d_pc_plus4 <= PC_STEP;
      end else if (d_flush) begin
         d_valid <= 1'b0;
         d_instr <= NOP_INSTR;
      end else if (d_stall) begin
         d_valid <= d_valid;
      end else if (fifo_pop) begin
         d_valid    <= 1'b1;
         d_instr    <= fifo_head.instr;
         d_pc       <= fifo_head.pc;
         d_pc_plus4 <= fifo_head.pc + PC_STEP;
      end else if (bypass) begin
         d_valid    <= 1'b1;
         d_instr    <= rsp_entry.instr;
         d_pc       <= rsp_entry.pc;
         d_pc_plus4 <= rsp_entry.pc + PC_STEP;
      end else begin
         d_valid <= 1'b0;
         d_instr <= NOP_INSTR;
      end
   end

`ifdef FETCH_BUBBLE_CNT_EN
   logic bubble_adv;
   assign bubble_adv = advance & ~fifo_pop & ~bypass;

   // Saturating count of bubbles entering decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_bubbles <= 32'd0;
      end else if (bubble_adv && perf_bubbles != 32'hFFFF_FFFF) begin
         perf_bubbles <= perf_bubbles + 32'd1;
      end else begin
         perf_bubbles <= perf_bubbles;
      end
   end
`endif

endmodule
